// File: rtl/nested_counter_pkg.sv
// Shared types and helpers for the nested loop counter.
//   state_t : FSM encoding (IDLE, RUN)
//   cnt_w() : width of the linear step index (sum of the three index widths)
package cnt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Pass length is at most 2^(xw+yw+cw) steps, so this width never overflows
    function automatic int cnt_w(input int xw, input int yw, input int cw);
        return xw + yw + cw;
    endfunction

endpackage

// File: rtl/nested_counter_if.sv
// Control/status bundle of nested_counter.
//   master : testbench / upstream side (drives start, clear, valid, limits)
//   slave  : counter side (drives indices, count, last flags, busy, done)
interface nested_counter_if #(
    parameter int X_W = 4,
    parameter int Y_W = 4,
    parameter int C_W = 4
);
    import cnt_pkg::*;
    localparam int CNT_W = cnt_w(X_W, Y_W, C_W);

    logic             i_start;
    logic             i_clear;
    logic             i_valid;
    logic [X_W-1:0]   i_lim_x;
    logic [Y_W-1:0]   i_lim_y;
    logic [C_W-1:0]   i_lim_c;
    logic [X_W-1:0]   o_x;
    logic [Y_W-1:0]   o_y;
    logic [C_W-1:0]   o_c;
    logic [CNT_W-1:0] o_count;
    logic             o_last_x;
    logic             o_last;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_clear, i_valid, i_lim_x, i_lim_y, i_lim_c,
        input  o_x, o_y, o_c, o_count, o_last_x, o_last, o_busy, o_done
    );

    modport slave (
        input  i_start, i_clear, i_valid, i_lim_x, i_lim_y, i_lim_c,
        output o_x, o_y, o_c, o_count, o_last_x, o_last, o_busy, o_done
    );
endinterface

// File: rtl/nested_counter_mod.sv
// Single modulo counter stage: counts 0..i_lim inclusive on i_en.
//   i_clk, i_arstn : clock, async active-low reset
//   i_en           : advance one step
//   i_clr          : synchronous clear to 0 (wins over i_en)
//   i_lim          : inclusive terminal value
//   o_val          : current value
//   o_wrap         : i_en while at the limit; enables the next outer stage
module mod_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_arstn,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_lim,
    output logic [W-1:0] o_val,
    output logic         o_wrap
);
    logic [W-1:0] val_q, val_d;

    assign o_wrap = i_en & (val_q == i_lim);

    always_comb begin
        val_d = val_q;
        if (i_clr)
            val_d = '0;
        else if (o_wrap)
            val_d = '0;
        else if (i_en)
            val_d = val_q + W'(1);
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn)
            val_q <= '0;
        else
            val_q <= val_d;
    end

    assign o_val = val_q;
endmodule

// File: rtl/nested_counter.sv
// Three-level nested loop counter (x innermost, then y, then c) with
// runtime limits latched on start, a start/done FSM and a done pulse.
//   i_clk, i_arstn : clock, async active-low reset
//   bus (slave)    : start/clear/valid, limits in; indices, count,
//                    last flags, busy and done out
module nested_counter
    import cnt_pkg::*;
#(
    parameter int X_W          = 4,
    parameter int Y_W          = 4,
    parameter int C_W          = 4,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic i_clk,
    input  logic i_arstn,
    nested_counter_if.slave bus
);
    localparam int CNT_W = cnt_w(X_W, Y_W, C_W);

    state_t           state_q, state_d;
    logic [X_W-1:0]   lim_x_q;
    logic [Y_W-1:0]   lim_y_q;
    logic [C_W-1:0]   lim_c_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q;

    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [C_W-1:0]   c;
    logic             x_wrap, y_wrap, c_wrap;

    logic run, accept, step, idx_clr, final_step;

    assign run     = (state_q == RUN);
    // clear dominates both start and valid
    assign accept  = ~run & bus.i_start & ~bus.i_clear;
    assign step    = run & bus.i_valid & ~bus.i_clear;
    assign idx_clr = bus.i_clear | accept;
    // c only wraps when x and y wrap in the same step, i.e. the final step
    assign final_step = c_wrap;

    mod_counter #(.W(X_W)) u_x (
        .i_clk(i_clk), .i_arstn(i_arstn), .i_en(step), .i_clr(idx_clr),
        .i_lim(lim_x_q), .o_val(x), .o_wrap(x_wrap)
    );
    mod_counter #(.W(Y_W)) u_y (
        .i_clk(i_clk), .i_arstn(i_arstn), .i_en(x_wrap), .i_clr(idx_clr),
        .i_lim(lim_y_q), .o_val(y), .o_wrap(y_wrap)
    );
    mod_counter #(.W(C_W)) u_c (
        .i_clk(i_clk), .i_arstn(i_arstn), .i_en(y_wrap), .i_clr(idx_clr),
        .i_lim(lim_c_q), .o_val(c), .o_wrap(c_wrap)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (bus.i_clear) begin
            state_d = IDLE;
            count_d = '0;
        end else if (accept) begin
            state_d = RUN;
            count_d = '0;
        end else if (step) begin
            if (final_step) begin
                state_d = AUTO_RESTART ? RUN : IDLE;
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            lim_x_q <= '0;
            lim_y_q <= '0;
            lim_c_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= step & final_step;
            // limits only move on an accepted start, so they hold for the pass
            if (accept) begin
                lim_x_q <= bus.i_lim_x;
                lim_y_q <= bus.i_lim_y;
                lim_c_q <= bus.i_lim_c;
            end
        end
    end

    assign bus.o_x      = x;
    assign bus.o_y      = y;
    assign bus.o_c      = c;
    assign bus.o_count  = count_q;
    assign bus.o_busy   = run;
    assign bus.o_done   = done_q;
    assign bus.o_last_x = run & (x == lim_x_q);
    assign bus.o_last   = run & (x == lim_x_q) & (y == lim_y_q) & (c == lim_c_q);
endmodule

// File: tb/tb_nested_counter.sv
module tb_nested_counter;
    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    nested_counter_if b0 ();
    nested_counter_if b1 ();

    nested_counter #(.AUTO_RESTART(1'b0)) dut0 (.i_clk(clk), .i_arstn(arstn), .bus(b0));
    nested_counter #(.AUTO_RESTART(1'b1)) dut1 (.i_clk(clk), .i_arstn(arstn), .bus(b1));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       start, clear, valid;
        logic [3:0] lx, ly, lc;
        logic [3:0] ex, ey, ec;
        logic [11:0] ecnt;
        logic       elx, el, ebusy, edone;
    } vec_t;

    vec_t tv[12];

    function automatic vec_t mk(logic s, logic cl, logic v, logic [3:0] lx, ly, lc,
                                logic [3:0] ex, ey, ec, logic [11:0] cnt,
                                logic elx, el, eb, ed);
        vec_t r;
        r.start = s; r.clear = cl; r.valid = v;
        r.lx = lx; r.ly = ly; r.lc = lc;
        r.ex = ex; r.ey = ey; r.ec = ec; r.ecnt = cnt;
        r.elx = elx; r.el = el; r.ebusy = eb; r.edone = ed;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv0(input logic s, input logic cl, input logic v,
                        input logic [3:0] lx, input logic [3:0] ly, input logic [3:0] lc);
        b0.i_start = s; b0.i_clear = cl; b0.i_valid = v;
        b0.i_lim_x = lx; b0.i_lim_y = ly; b0.i_lim_c = lc;
    endtask

    function automatic logic [27:0] out0();
        return {b0.o_x, b0.o_y, b0.o_c, b0.o_count,
                b0.o_last_x, b0.o_last, b0.o_busy, b0.o_done};
    endfunction

    initial begin
        drv0(0, 0, 0, 0, 0, 0);
        b1.i_start = 0; b1.i_clear = 0; b1.i_valid = 0;
        b1.i_lim_x = 0; b1.i_lim_y = 0; b1.i_lim_c = 0;

        // table: lim (1,0,1) pass, ignored starts, idle valid, zero limits, clear vs start
        tv[0]  = mk(1,0,1, 1,0,1,  0,0,0,  0, 0,0,1,0);
        tv[1]  = mk(0,0,1, 0,0,0,  1,0,0,  1, 1,0,1,0);
        tv[2]  = mk(0,0,0, 0,0,0,  1,0,0,  1, 1,0,1,0);
        tv[3]  = mk(1,0,1, 3,3,3,  0,0,1,  2, 0,0,1,0);
        tv[4]  = mk(0,0,1, 0,0,0,  1,0,1,  3, 1,1,1,0);
        tv[5]  = mk(1,0,1, 2,2,2,  0,0,0,  0, 0,0,0,1);
        tv[6]  = mk(0,0,0, 0,0,0,  0,0,0,  0, 0,0,0,0);
        tv[7]  = mk(0,0,1, 0,0,0,  0,0,0,  0, 0,0,0,0);
        tv[8]  = mk(1,0,0, 0,0,0,  0,0,0,  0, 1,1,1,0);
        tv[9]  = mk(0,0,0, 5,5,5,  0,0,0,  0, 1,1,1,0);
        tv[10] = mk(0,0,1, 0,0,0,  0,0,0,  0, 0,0,0,1);
        tv[11] = mk(1,1,0, 2,1,1,  0,0,0,  0, 0,0,0,0);

        #12;
        chk("reset_state", out0(), 28'h0);
        @(negedge clk);
        arstn = 1'b1;
        tick();
        chk("idle_after_reset", out0(), 28'h0);

        for (int i = 0; i < 12; i++) begin
            drv0(tv[i].start, tv[i].clear, tv[i].valid, tv[i].lx, tv[i].ly, tv[i].lc);
            tick();
            chk($sformatf("vec%0d", i), out0(),
                {tv[i].ex, tv[i].ey, tv[i].ec, tv[i].ecnt,
                 tv[i].elx, tv[i].el, tv[i].ebusy, tv[i].edone});
        end
        drv0(0, 0, 0, 0, 0, 0);
        tick();

        // basic pass (2,1,1), valid held high: 12 steps
        drv0(1, 0, 0, 2, 1, 1);
        tick();
        drv0(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("basic_k%0d", k),
                {b0.o_x, b0.o_y, b0.o_c, b0.o_count, b0.o_busy, b0.o_done},
                {4'(k % 3), 4'((k / 3) % 2), 4'(k / 6), 12'(k), 1'b1, 1'b0});
            tick();
        end
        drv0(0, 0, 0, 0, 0, 0);
        chk("basic_done", {b0.o_done, b0.o_busy, b0.o_x, b0.o_count}, {1'b1, 1'b0, 4'd0, 12'd0});
        tick();
        chk("basic_done_gone", b0.o_done, 1'b0);

        // legacy mod-13: valid on alternate cycles
        drv0(1, 0, 0, 12, 0, 0);
        tick();
        for (int k = 0; k < 13; k++) begin
            drv0(0, 0, 1, 0, 0, 0);
            tick();
            chk($sformatf("legacy_step%0d", k), {b0.o_x, b0.o_done},
                {(k == 12) ? 4'd0 : 4'(k + 1), (k == 12) ? 1'b1 : 1'b0});
            drv0(0, 0, 0, 0, 0, 0);
            tick();
            chk($sformatf("legacy_hold%0d", k), {b0.o_x, b0.o_done},
                {(k == 12) ? 4'd0 : 4'(k + 1), 1'b0});
        end

        // all-15 limits: 4096 steps, count reaches 4095
        drv0(1, 0, 0, 15, 15, 15);
        tick();
        drv0(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4096; k++) begin
            chk($sformatf("full_k%0d", k), {b0.o_x, b0.o_y, b0.o_c, b0.o_count, b0.o_done},
                {4'(k % 16), 4'((k / 16) % 16), 4'(k / 256), 12'(k), 1'b0});
            if (k == 4095)
                chk("full_last", {b0.o_last, b0.o_count}, {1'b1, 12'd4095});
            tick();
        end
        drv0(0, 0, 0, 0, 0, 0);
        chk("full_done", {b0.o_done, b0.o_busy, b0.o_count}, {1'b1, 1'b0, 12'd0});
        tick();

        // clear together with valid at count 5
        drv0(1, 0, 0, 2, 1, 1);
        tick();
        drv0(0, 0, 1, 0, 0, 0);
        repeat (5) tick();
        chk("prio_count5", b0.o_count, 12'd5);
        drv0(0, 1, 1, 0, 0, 0);
        tick();
        drv0(0, 0, 0, 0, 0, 0);
        chk("prio_clear", out0(), 28'h0);
        tick();
        chk("prio_no_done", b0.o_done, 1'b0);

        // start during RUN must not disturb limits or indices
        drv0(1, 0, 0, 2, 1, 1);
        tick();
        drv0(0, 0, 1, 0, 0, 0);
        repeat (2) tick();
        drv0(1, 0, 0, 0, 0, 0);
        tick();
        chk("run_start_hold", {b0.o_x, b0.o_y, b0.o_count, b0.o_last_x, b0.o_last},
            {4'd2, 4'd0, 12'd2, 1'b1, 1'b0});
        drv0(0, 0, 1, 0, 0, 0);
        tick();
        chk("run_start_limits", {b0.o_x, b0.o_y, b0.o_c, b0.o_count}, {4'd0, 4'd1, 4'd0, 12'd3});
        drv0(0, 1, 0, 0, 0, 0);
        tick();

        // async reset mid-pass at x=3
        drv0(1, 0, 0, 5, 0, 0);
        tick();
        drv0(0, 0, 1, 0, 0, 0);
        repeat (3) tick();
        drv0(0, 0, 0, 0, 0, 0);
        chk("areset_pre", b0.o_x, 4'd3);
        #2 arstn = 1'b0;
        #1 chk("areset_async", out0(), 28'h0);
        tick();
        chk("areset_no_done", out0(), 28'h0);
        arstn = 1'b1;
        tick();

        // auto restart: lim (1,0,0), done every 2 valids, limits stay latched
        b1.i_start = 1; b1.i_lim_x = 1; b1.i_lim_y = 0; b1.i_lim_c = 0;
        tick();
        b1.i_start = 0; b1.i_lim_x = 3; b1.i_lim_y = 2; b1.i_lim_c = 1;
        b1.i_valid = 1;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk($sformatf("auto_j%0d", j), {b1.o_x, b1.o_busy, b1.o_done},
                {(j % 2 == 0) ? 4'd1 : 4'd0, 1'b1, (j % 2 == 1) ? 1'b1 : 1'b0});
        end
        b1.i_valid = 0;
        tick();
        chk("auto_idle_hold", {b1.o_busy, b1.o_done, b1.o_x}, {1'b1, 1'b0, 4'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
